quad_step_decoder: RTL and testbench
====================================

Name: quad_step_decoder

Overview:
- Upstream front-end for the 4-bit up/down counter.
- Decodes a two-channel quadrature input (A/B) into a one-cycle step pulse plus a direction level.
  - step drives the counter's count-enable.
  - up_down drives the counter's up_down input.
- Handles metastability, glitch rejection and illegal-transition detection, so the counter only sees clean, single-cycle events.

Parameters:
- FILT_LEN, 3: consecutive identical synchronized samples (1..15) required before a channel's filtered level changes.
- ERR_W, 4: width of the saturating illegal-transition counter.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- a_in  input  1  quadrature channel A; asynchronous to clk.
- b_in  input  1  quadrature channel B; asynchronous to clk.
- en  input  1  decode enable; 0 suppresses step/err while tracking continues.
- clr_err  input  1  synchronous clear of err_cnt.
- step  output  1  one-cycle pulse per legal quadrature transition.
- up_down  output  1  direction of last legal step: 1 = up, 0 = down.
- err  output  1  one-cycle pulse per illegal (double-bit) transition.
- err_cnt  output  ERR_W  saturating count of illegal transitions.

Behaviour:
- Reset (rst=0, async):
  - step=0, up_down=0, err=0, err_cnt=0.
  - Synchronizers, filtered levels and prev_phase cleared to 0.
  - FSM enters INIT.
- Synchronizer: two flops per channel; no logic between them.
- Glitch filter, per channel:
  - Counter increments while the synchronized value differs from the filtered value, and clears when they match.
  - When the counter reaches FILT_LEN, the filtered value takes the new level and the counter clears.
  - Pulses shorter than FILT_LEN cycles (after synchronization) are never seen.
- phase = {a_f, b_f}.
  - Up sequence: 00→01→11→10→00.
  - Down sequence: reverse.
  - 00↔11 or 01↔10 in a single update is illegal.
- FSM INIT:
  - prev_phase loads phase every cycle.
  - step and err are held 0.
  - Exits to TRACK after FILT_LEN+2 cycles, so a nonzero idle input at reset release never produces a step or err.
- FSM TRACK: each cycle, compare phase against prev_phase, then load prev_phase := phase.
  - Equal: nothing.
  - Legal up: step=1, up_down=1 (if en=1).
  - Legal down: step=1, up_down=0 (if en=1).
  - Illegal: err=1 (if en=1) and err_cnt increments, saturating at 2^ERR_W−1. No step. up_down unchanged. prev_phase resyncs to the new phase.
- en=0: filter and prev_phase keep tracking; step, err and the err_cnt increment are suppressed. Re-enabling never emits a step for transitions that occurred while disabled.
- Outputs are registered. Latency: step/err assert exactly FILT_LEN+2 clk edges after the edge that first samples the new input level (5 edges at default). Width is exactly one cycle.
- Back-to-back legal transitions produce one step each, provided each level is held ≥ FILT_LEN+2 cycles.
- clr_err=1 sets err_cnt=0 next cycle. If it coincides with an illegal transition, the clear has priority (err_cnt=0) and err still pulses.
- rst asserted mid-operation: outputs clear immediately; the FSM restarts in INIT.
- No combinational path from any input to any output.

Test Plan:
- Reset with a=b=0, release; drive up sequence 01,11,10,00, each held 10 cycles → 4 step pulses, each 1 cycle wide; first pulse 5 edges after sampling; up_down=1 from first step; err_cnt=0.
- From 00, drive down sequence 10,11,01,00 → 4 steps; up_down=0 from first step; counter downstream returns to its start value after the up+down runs.
- a_in high for 2 cycles then low (FILT_LEN=3) → no step, no err, up_down unchanged.
- From phase 00, toggle a and b on the same cycle to 11 → err pulses once, err_cnt=1, no step. Repeat 16 illegal jumps → err_cnt saturates at 15. Assert clr_err together with a further illegal jump → err pulses, err_cnt=0.
- en=0, apply two legal up transitions → no step; set en=1, apply one more up transition → exactly one step, up_down=1.
- Drive phase to 11, assert rst mid-sequence, release with inputs still 11 → all outputs 0, no err/step during INIT; then 11→10 → one step with up_down=1.

Source files
------------

// File: rtl/quad_step_decoder.sv
//======================================================================
// Module   : quad_step_decoder
// Brief    : Quadrature A/B front-end: sync, glitch filter, step/dir/err.
// Revision : 1.0
//======================================================================
`default_nettype none

module quad_step_decoder #(
    parameter int FILT_LEN = 3,
    parameter int ERR_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             en,
    input  logic             clr_err,
    output logic             step,
    output logic             up_down,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int                  c_FCNT_W    = 4;
    localparam int                  c_INIT_W    = 5;
    localparam logic [c_FCNT_W-1:0] c_FILT_LAST = c_FCNT_W'(FILT_LEN - 1);
    localparam logic [c_INIT_W-1:0] c_INIT_LAST = c_INIT_W'(FILT_LEN + 2);
    localparam logic [ERR_W-1:0]    c_ERR_MAX   = {ERR_W{1'b1}};

    typedef enum logic [0:0] {
        S_INIT  = 1'b0,
        S_TRACK = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [c_INIT_W-1:0] r_init_cnt, w_init_cnt_nxt;
    logic [1:0]          w_raw, w_phase, r_prev_phase;
    logic                r_step, w_step_nxt;
    logic                r_up_down, w_up_down_nxt;
    logic                r_err, w_err_nxt;
    logic [ERR_W-1:0]    r_err_cnt, w_err_cnt_nxt;
    logic                w_is_up, w_is_down, w_is_bad;

    assign w_raw = {a_in, b_in};

    // Bit 1 is channel A, bit 0 is channel B, matching phase = {a_f, b_f}.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic                r_sync1, r_sync2, r_filt;
            logic [c_FCNT_W-1:0] r_fcnt;
            logic                w_diff, w_hit;

            assign w_diff = r_sync2 ^ r_filt;
            assign w_hit  = w_diff && (r_fcnt == c_FILT_LAST);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_filt  <= 1'b0;
                    r_fcnt  <= '0;
                end else begin
                    r_sync1 <= w_raw[gi];
                    r_sync2 <= r_sync1;
                    if (w_hit) begin
                        r_filt <= r_sync2;
                        r_fcnt <= '0;
                    end else if (w_diff) begin
                        r_fcnt <= r_fcnt + 1'b1;
                    end else begin
                        r_fcnt <= '0;
                    end
                end
            end

            assign w_phase[gi] = r_filt;
        end
    endgenerate

    function automatic logic [1:0] f_up_next(input logic [1:0] p);
        case (p)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    assign w_is_up   = (w_phase == f_up_next(r_prev_phase));
    assign w_is_down = (r_prev_phase == f_up_next(w_phase));
    assign w_is_bad  = ((w_phase ^ r_prev_phase) == 2'b11);

    // INIT outlasts the sync+filter pipeline so a nonzero idle level is absorbed silently.
    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_step_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_up_down_nxt  = r_up_down;
        w_err_cnt_nxt  = r_err_cnt;
        case (r_state)
            S_INIT: begin
                if (r_init_cnt == c_INIT_LAST) begin
                    w_state_nxt = S_TRACK;
                end else begin
                    w_init_cnt_nxt = r_init_cnt + 1'b1;
                end
            end
            S_TRACK: begin
                if (en) begin
                    if (w_is_up) begin
                        w_step_nxt    = 1'b1;
                        w_up_down_nxt = 1'b1;
                    end else if (w_is_down) begin
                        w_step_nxt    = 1'b1;
                        w_up_down_nxt = 1'b0;
                    end else if (w_is_bad) begin
                        w_err_nxt = 1'b1;
                        if (r_err_cnt != c_ERR_MAX) begin
                            w_err_cnt_nxt = r_err_cnt + 1'b1;
                        end
                    end
                end
            end
            default: w_state_nxt = S_INIT;
        endcase
        if (clr_err) begin
            w_err_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_INIT;
            r_init_cnt   <= '0;
            r_prev_phase <= 2'b00;
            r_step       <= 1'b0;
            r_up_down    <= 1'b0;
            r_err        <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_init_cnt   <= w_init_cnt_nxt;
            r_prev_phase <= w_phase;
            r_step       <= w_step_nxt;
            r_up_down    <= w_up_down_nxt;
            r_err        <= w_err_nxt;
            r_err_cnt    <= w_err_cnt_nxt;
        end
    end

    assign step    = r_step;
    assign up_down = r_up_down;
    assign err     = r_err;
    assign err_cnt = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_quad_step_decoder.sv
//======================================================================
// Module   : tb_quad_step_decoder
// Brief    : Table-driven, scoreboarded bench for quad_step_decoder.
// Revision : 1.0
//======================================================================
`default_nettype none

module tb_quad_step_decoder;

    localparam int FILT_LEN = 3;
    localparam int ERR_W    = 4;
    localparam int HOLD     = 10;
    localparam int LAT      = FILT_LEN + 2;
    localparam int K_NONE   = 0;
    localparam int K_STEP   = 1;
    localparam int K_ERR    = 2;

    logic             clk     = 1'b0;
    logic             rst     = 1'b0;
    logic             a_in    = 1'b0;
    logic             b_in    = 1'b0;
    logic             en      = 1'b1;
    logic             clr_err = 1'b0;
    logic             step;
    logic             up_down;
    logic             err;
    logic [ERR_W-1:0] err_cnt;

    typedef struct {
        logic             a;
        logic             b;
        logic             en;
        logic             clr;
        int               kind;
        logic             up;
        logic [ERR_W-1:0] cnt;
    } vec_t;

    typedef struct {
        int               edge_n;
        logic             step;
        logic             err;
        logic             up;
        logic [ERR_W-1:0] cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    quad_step_decoder #(
        .FILT_LEN (FILT_LEN),
        .ERR_W    (ERR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a_in     (a_in),
        .b_in     (b_in),
        .en       (en),
        .clr_err  (clr_err),
        .step     (step),
        .up_down  (up_down),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            edge_cnt = edge_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Pulse monitor: every step/err pulse must match the oldest scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0 && sb[0].edge_n < edge_cnt) begin
                n_checks = n_checks + 1;
                n_errors = n_errors + 1;
                $display("FAIL missed_pulse: no pulse by edge %0d, expected at edge %0d",
                         edge_cnt, sb[0].edge_n);
                void'(sb.pop_front());
            end
            if (step === 1'b1 || err === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks = n_checks + 1;
                    n_errors = n_errors + 1;
                    $display("FAIL unexpected_pulse: step=%b err=%b at edge %0d, expected none",
                             step, err, edge_cnt);
                end else begin
                    e = sb.pop_front();
                    check("pulse_edge", 32'(edge_cnt), 32'(e.edge_n));
                    check("pulse_step", 32'(step), 32'(e.step));
                    check("pulse_err", 32'(err), 32'(e.err));
                    check("pulse_up_down", 32'(up_down), 32'(e.up));
                    check("pulse_err_cnt", 32'(err_cnt), 32'(e.cnt));
                end
            end
        end
    end

    task automatic add(input logic a, input logic b, input logic e, input logic c,
                       input int kind, input logic up, input int cnt);
        vec_t v;
        v.a    = a;
        v.b    = b;
        v.en   = e;
        v.clr  = c;
        v.kind = kind;
        v.up   = up;
        v.cnt  = ERR_W'(cnt);
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        a_in    = v.a;
        b_in    = v.b;
        en      = v.en;
        clr_err = v.clr;
        if (v.kind != K_NONE) begin
            e.edge_n = edge_cnt + 1 + LAT;
            e.step   = (v.kind == K_STEP);
            e.err    = (v.kind == K_ERR);
            e.up     = v.up;
            e.cnt    = v.cnt;
            sb.push_back(e);
        end
        repeat (HOLD) @(negedge clk);
        check("up_down_after", 32'(up_down), 32'(v.up));
        check("err_cnt_after", 32'(err_cnt), 32'(v.cnt));
    endtask

    initial begin
        vec_t fin;

        // up run, then down run (indices 0..7)
        add(0, 1, 1, 0, K_STEP, 1, 0);
        add(1, 1, 1, 0, K_STEP, 1, 0);
        add(1, 0, 1, 0, K_STEP, 1, 0);
        add(0, 0, 1, 0, K_STEP, 1, 0);
        add(1, 0, 1, 0, K_STEP, 0, 0);
        add(1, 1, 1, 0, K_STEP, 0, 0);
        add(0, 1, 1, 0, K_STEP, 0, 0);
        add(0, 0, 1, 0, K_STEP, 0, 0);
        // illegal jumps up to saturation, then clear coinciding with a jump
        add(1, 1, 1, 0, K_ERR, 0, 1);
        for (int k = 0; k < 16; k++) begin
            add((k % 2) != 0, (k % 2) != 0, 1, 0, K_ERR, 0, (k + 2 > 15) ? 15 : k + 2);
        end
        add(0, 0, 1, 1, K_ERR, 0, 0);
        // disabled transitions, then one enabled up step
        add(0, 1, 0, 0, K_NONE, 0, 0);
        add(1, 1, 0, 0, K_NONE, 0, 0);
        add(1, 0, 1, 0, K_STEP, 1, 0);
        // 10->01 illegal, then 01->11 legal up
        add(0, 1, 1, 0, K_ERR, 1, 1);
        add(1, 1, 1, 0, K_STEP, 1, 1);

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_step", 32'(step), 32'd0);
        check("rst_up_down", 32'(up_down), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b1;
        repeat (HOLD) @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            if (i == 7) begin
                // 2-cycle glitch on A must never reach the filtered phase
                @(negedge clk);
                a_in = 1'b1;
                repeat (2) @(negedge clk);
                a_in = 1'b0;
                repeat (HOLD) @(negedge clk);
                check("glitch_up_down", 32'(up_down), 32'd0);
                check("glitch_err_cnt", 32'(err_cnt), 32'd0);
            end
        end

        // Reset mid-operation with inputs parked at 11
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_step", 32'(step), 32'd0);
        check("midrst_up_down", 32'(up_down), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        check("midrst_err_cnt", 32'(err_cnt), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        check("init_up_down", 32'(up_down), 32'd0);
        check("init_err_cnt", 32'(err_cnt), 32'd0);

        fin.a    = 1'b1;
        fin.b    = 1'b0;
        fin.en   = 1'b1;
        fin.clr  = 1'b0;
        fin.kind = K_STEP;
        fin.up   = 1'b1;
        fin.cnt  = '0;
        apply(fin);

        repeat (HOLD) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
